// File: rtl/char_draw_pkg.sv
// Shared constants and FSM encoding for the character cell draw controller.
package char_draw_pkg;

    localparam int CELL_W_DEF   = 10;
    localparam int CELL_H_DEF   = 10;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam int COORD_W  = 8;
    localparam int SUM_W    = COORD_W + 1;
    localparam int COLOUR_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/char_scan_counter.sv
// Row-major col/row offset counter walking one glyph cell; last flags the final pixel.
module char_scan_counter
    import char_draw_pkg::*;
#(
    parameter int CELL_W = CELL_W_DEF,
    parameter int CELL_H = CELL_H_DEF
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               step,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               last
);

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic               col_wrap;

    assign col_wrap = (col_q == COORD_W'(CELL_W - 1));
    assign last     = col_wrap && (row_q == COORD_W'(CELL_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            if (col_wrap) begin
                col_d = '0;
                // wrapping on the final pixel leaves the counter ready for the next draw
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        col_q <= col_d;
        row_q <= row_d;
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/char_draw_ctrl.sv
// Scans one glyph cell through an external renderer and plots the visible pixels.
// Optional feature macro CHAR_BG_FILL_EN: unset glyph pixels plot the latched req_bg colour.
module char_draw_ctrl
    import char_draw_pkg::*;
#(
    parameter int CELL_W   = CELL_W_DEF,
    parameter int CELL_H   = CELL_H_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [COORD_W-1:0]  req_x,
    input  logic [COORD_W-1:0]  req_y,
    input  logic [COLOUR_W-1:0] req_bg,
    output logic [COORD_W-1:0]  glyph_x,
    output logic [COORD_W-1:0]  glyph_y,
    output logic [COORD_W-1:0]  flush_x,
    output logic [COORD_W-1:0]  flush_y,
    input  logic [COLOUR_W-1:0] glyph_colour,
    input  logic                glyph_enable,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                plot,
    output logic                done
);

    state_t              state_q;
    logic                req_ready_q, done_q, plot_q;
    logic [COORD_W-1:0]  org_x_q, org_y_q;
    logic [COORD_W-1:0]  plot_x_q, plot_y_q;
    logic [COLOUR_W-1:0] plot_colour_q;

    logic [COORD_W-1:0]  scan_col, scan_row;
    logic                scan_last, accept;
    logic [SUM_W-1:0]    sum_x, sum_y;
    logic                clip, pix_on;
    logic [COLOUR_W-1:0] pix_colour;

    assign accept = req_valid && req_ready_q;

    char_scan_counter #(
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_scan (
        .clk   (clk),
        .clear (reset || accept),
        .step  (state_q == ST_SCAN),
        .col   (scan_col),
        .row   (scan_row),
        .last  (scan_last)
    );

    // Bit 8 of each sum is the carry out of the 8-bit screen coordinate.
    assign sum_x = {1'b0, org_x_q} + {1'b0, scan_col};
    assign sum_y = {1'b0, org_y_q} + {1'b0, scan_row};
    assign clip  = sum_x[COORD_W] || sum_y[COORD_W]
                || (sum_x >= SUM_W'(SCREEN_W)) || (sum_y >= SUM_W'(SCREEN_H));

    assign flush_x = sum_x[COORD_W-1:0];
    assign flush_y = sum_y[COORD_W-1:0];

`ifdef CHAR_BG_FILL_EN
    logic [COLOUR_W-1:0] bg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bg_q <= '0;
        end else if (accept) begin
            bg_q <= req_bg;
        end
    end

    assign pix_colour = glyph_enable ? glyph_colour : bg_q;
    assign pix_on     = !clip;
`else
    logic unused_req_bg;
    assign unused_req_bg = ^req_bg;

    assign pix_colour = glyph_colour;
    assign pix_on     = !clip && glyph_enable;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            done_q        <= 1'b0;
            plot_q        <= 1'b0;
            org_x_q       <= '0;
            org_y_q       <= '0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        org_x_q     <= req_x;
                        org_y_q     <= req_y;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    plot_q        <= pix_on;
                    plot_x_q      <= flush_x;
                    plot_y_q      <= flush_y;
                    plot_colour_q <= pix_colour;
                    if (scan_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                // DRAIN lets the last pixel's plot leave the output register before done.
                ST_DRAIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign done        = done_q;
    assign plot        = plot_q;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_colour = plot_colour_q;
    assign glyph_x     = org_x_q;
    assign glyph_y     = org_y_q;

endmodule

// File: tb/tb_char_draw_ctrl.sv
// Directed bench for char_draw_ctrl with a cycle-indexed expectation model and a glyph 'A' renderer.
`timescale 1ns/1ps
module tb_char_draw_ctrl;

    localparam int MAXC     = 2048;
    localparam int CELL_W   = 10;
    localparam int CELL_H   = 10;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

`ifdef CHAR_BG_FILL_EN
    localparam bit BG_EN = 1'b1;
`else
    localparam bit BG_EN = 1'b0;
`endif

    // Hand-derived expectations for the directed scenarios.
    localparam int EXP_A_CNT   = BG_EN ? 100 : 30;
    localparam int EXP_A_FIRST = BG_EN ? 2 : 6;
    localparam int EXP_A_FX    = BG_EN ? 10 : 14;
    localparam int EXP_A_FC    = BG_EN ? 5 : 63;
    localparam int EXP_B_CNT   = BG_EN ? 25 : 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = 8'd0, req_y = 8'd0;
    logic [5:0] req_bg = 6'd0;
    logic [7:0] glyph_x, glyph_y, flush_x, flush_y;
    logic [5:0] glyph_colour;
    logic       glyph_enable;
    logic [7:0] plot_x, plot_y;
    logic [5:0] plot_colour;
    logic       plot, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bit         exp_plot  [MAXC];
    bit         exp_done  [MAXC];
    bit         exp_ready [MAXC];
    logic [7:0] exp_px    [MAXC];
    logic [7:0] exp_py    [MAXC];
    logic [5:0] exp_pc    [MAXC];
    logic [7:0] exp_gx    [MAXC];
    logic [7:0] exp_gy    [MAXC];

    char_draw_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_bg       (req_bg),
        .glyph_x      (glyph_x),
        .glyph_y      (glyph_y),
        .flush_x      (flush_x),
        .flush_y      (flush_y),
        .glyph_colour (glyph_colour),
        .glyph_enable (glyph_enable),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_colour  (plot_colour),
        .plot         (plot),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Glyph 'A', 30 set pixels; leftmost column is bit 9.
    function automatic logic [9:0] glyph_row(input int r);
        case (r)
            0: return 10'b0000110000;
            1: return 10'b0001001000;
            2: return 10'b0010000100;
            3: return 10'b0010000100;
            4: return 10'b0100000010;
            5: return 10'b0111111110;
            6: return 10'b0100000010;
            7: return 10'b1000000001;
            8: return 10'b1100000011;
            9: return 10'b1100000011;
            default: return 10'b0;
        endcase
    endfunction

    function automatic bit glyph_bit(input int r, input int c);
        logic [9:0] rowbits;
        rowbits = glyph_row(r);
        return rowbits[9 - c];
    endfunction

    logic [7:0] dx, dy;
    always_comb begin
        dx = flush_x - glyph_x;
        dy = flush_y - glyph_y;
        glyph_enable = 1'b0;
        if (dx < 8'd10 && dy < 8'd10) glyph_enable = glyph_bit(int'(dy), int'(dx));
    end
    assign glyph_colour = 6'h3F;

    // Model: request handshaken in cycle t -> pixel k plotted in cycle t+2+k, done t+102, idle t+103.
    function automatic void model_draw(input int t, input logic [7:0] ox, input logic [7:0] oy,
                                       input logic [5:0] bg);
        for (int c = t + 1; c < MAXC; c++) begin
            exp_gx[c] = ox;
            exp_gy[c] = oy;
        end
        for (int c = t + 1; c <= t + 102 && c < MAXC; c++) begin
            exp_ready[c] = 1'b0;
            exp_plot[c]  = 1'b0;
            exp_done[c]  = 1'b0;
        end
        if (t + 102 < MAXC) exp_done[t + 102] = 1'b1;
        for (int r = 0; r < CELL_H; r++) begin
            for (int k = 0; k < CELL_W; k++) begin
                int x, y, c;
                bit en;
                x  = int'(ox) + k;
                y  = int'(oy) + r;
                c  = t + 2 + r * CELL_W + k;
                en = glyph_bit(r, k);
                if (c < MAXC && x < SCREEN_W && y < SCREEN_H && (en || BG_EN)) begin
                    exp_plot[c] = 1'b1;
                    exp_px[c]   = x[7:0];
                    exp_py[c]   = y[7:0];
                    exp_pc[c]   = en ? 6'h3F : bg;
                end
            end
        end
    endfunction

    function automatic void model_reset(input int tr);
        for (int c = tr + 1; c < MAXC; c++) begin
            exp_plot[c]  = 1'b0;
            exp_done[c]  = 1'b0;
            exp_ready[c] = 1'b1;
            exp_gx[c]    = 8'd0;
            exp_gy[c]    = 8'd0;
        end
    endfunction

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (reset) model_reset(cyc);
            else if (req_valid && exp_ready[cyc]) model_draw(cyc, req_x, req_y, req_bg);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("plot", 32'(plot), 32'(exp_plot[cyc]));
            chk("done", 32'(done), 32'(exp_done[cyc]));
            chk("req_ready", 32'(req_ready), 32'(exp_ready[cyc]));
            chk("glyph_x", 32'(glyph_x), 32'(exp_gx[cyc]));
            chk("glyph_y", 32'(glyph_y), 32'(exp_gy[cyc]));
            if (exp_plot[cyc]) begin
                chk("plot_x", 32'(plot_x), 32'(exp_px[cyc]));
                chk("plot_y", 32'(plot_y), 32'(exp_py[cyc]));
                chk("plot_colour", 32'(plot_colour), 32'(exp_pc[cyc]));
            end
        end
    end

    // One draw: handshake, then 110 observed cycles with a stray request at +30,
    // scrambled request inputs, and an optional reset in cycle +abort_at.
    task automatic run_draw(input logic [7:0] ox, input logic [7:0] oy, input logic [5:0] bg,
                            input int abort_at, output int cnt, output int first_off,
                            output int fx, output int fy, output int done_off,
                            output int bad, output int late);
        int t;
        cnt = 0; first_off = -1; fx = -1; fy = -1; done_off = -1; bad = 0; late = 0; t = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = ox; req_y = oy; req_bg = bg;
        for (int i = 0; i < 8 && t < 0; i++) begin
            @(negedge clk);
            if (req_ready) t = cyc;
        end
        chk("accept_seen", 32'(t >= 0), 32'd1);
        if (t >= 0) begin
            for (int i = 0; i < 110; i++) begin
                @(posedge clk); #1;
                req_valid = (cyc == t + 30);
                req_x = ~ox; req_y = ~oy; req_bg = ~bg;
                reset = (abort_at >= 0 && cyc == t + abort_at);
                @(negedge clk);
                if (plot) begin
                    cnt++;
                    if (first_off < 0) begin
                        first_off = cyc - t; fx = int'(plot_x); fy = int'(plot_y);
                    end
                    if (plot_x >= 8'd160 || plot_y >= 8'd120 || plot_x < 8'd4) bad++;
                    if (abort_at >= 0 && cyc - t > abort_at) late++;
                end
                if (done && done_off < 0) done_off = cyc - t;
            end
        end
        req_valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int cnt, first_off, fx, fy, done_off, bad, late;
        int acc [3];
        int acc_n, g2, g3;
        for (int c = 0; c < MAXC; c++) begin
            exp_plot[c] = 1'b0; exp_done[c] = 1'b0; exp_ready[c] = 1'b1;
            exp_px[c] = 8'd0; exp_py[c] = 8'd0; exp_pc[c] = 6'd0;
            exp_gx[c] = 8'd0; exp_gy[c] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_glyph_x", 32'(glyph_x), 32'd0);
        chk("rst_flush_x", 32'(flush_x), 32'd0);
        chk("rst_plot_colour", 32'(plot_colour), 32'd0);

        run_draw(8'd10, 8'd20, 6'h05, -1, cnt, first_off, fx, fy, done_off, bad, late);
        chk("A_count", cnt, EXP_A_CNT);
        chk("A_first_cycle", first_off, EXP_A_FIRST);
        chk("A_first_x", fx, EXP_A_FX);
        chk("A_first_y", fy, 20);
        chk("A_done_cycle", done_off, 102);

        run_draw(8'd155, 8'd115, 6'h05, -1, cnt, first_off, fx, fy, done_off, bad, late);
        chk("edge_count", cnt, EXP_B_CNT);
        chk("edge_offscreen", bad, 0);
        chk("edge_done_cycle", done_off, 102);

        run_draw(8'd250, 8'd0, 6'h05, -1, cnt, first_off, fx, fy, done_off, bad, late);
        chk("carry_count", cnt, 0);
        chk("carry_wrapped", bad, 0);
        chk("carry_done_cycle", done_off, 102);

        run_draw(8'd10, 8'd20, 6'h05, 50, cnt, first_off, fx, fy, done_off, bad, late);
        chk("abort_late_plots", late, 0);
        chk("abort_done", done_off, -1);
        chk("abort_ready", 32'(req_ready), 32'd1);

        run_draw(8'd10, 8'd20, 6'h05, -1, cnt, first_off, fx, fy, done_off, bad, late);
        chk("after_abort_count", cnt, EXP_A_CNT);
        chk("after_abort_done", done_off, 102);

        acc[0] = 0; acc[1] = 0; acc[2] = 0; acc_n = 0; g2 = -1; g3 = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = 8'd10; req_y = 8'd20; req_bg = 6'h05;
        for (int i = 0; i < 400 && acc_n < 3; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc[acc_n] = cyc;
                acc_n++;
            end
            if (acc_n == 2 && cyc == acc[1] + 60) g2 = int'(glyph_x);
            @(posedge clk); #1;
            if (acc_n == 2 && cyc == acc[1] + 50) begin
                req_x = 8'd30; req_y = 8'd40;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc_n, 3);
        chk("b2b_spacing1", acc[1] - acc[0], 103);
        chk("b2b_spacing2", acc[2] - acc[1], 103);
        repeat (10) @(negedge clk);
        g3 = int'(glyph_x);
        chk("b2b_draw2_origin", g2, 10);
        chk("b2b_draw3_origin", g3, 30);
        repeat (100) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
